mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one memory port between two requesters: port 0 is instruction fetch and port 1 is data access.
- Runs a round-robin, grant-hold FSM.
- Drives the select line of the team's N-bit 2:1 mux instance to steer the winning address onto the memory port.
- Sits between the fetch/LSU stages and a multi-cycle memory that signals completion with mem_ready.

Parameters:
- N, 32: address width in bits.
- TIMEOUT, 16: watchdog limit in cycles. Used only when ARB_TIMEOUT_EN is defined. Must be ≥ 2.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req0  in  1  port-0 request; held high until done0
- req1  in  1  port-1 request; held high until done1
- addr0  in  N  port-0 address; stable while req0 is high
- addr1  in  N  port-1 address; stable while req1 is high
- mem_ready  in  1  memory completes the current access this cycle
- gnt0  out  1  port 0 owns the memory port
- gnt1  out  1  port 1 owns the memory port
- done0  out  1  one-cycle completion pulse for port 0
- done1  out  1  one-cycle completion pulse for port 1
- mem_valid  out  1  access in progress
- mem_sel  out  1  mux select; 0 selects addr0, 1 selects addr1
- mem_addr  out  N  selected address
- timeout_err  out  1  one-cycle watchdog abort pulse; tied 0 without ARB_TIMEOUT_EN

Behaviour:
- Clocking and reset: single clock; reset is synchronous and active-high, on ports clk and rst.
- Reset values:
  - state = IDLE
  - gnt0 = gnt1 = 0, mem_valid = 0, mem_sel = 0, done0 = done1 = 0, timeout_err = 0
  - last_grant = 1, so port 0 wins the first tie
- FSM states: IDLE, BUSY0, BUSY1.
  - gntX, mem_valid and mem_sel are registered decodes of the state.
  - BUSY0 gives gnt0 = 1, mem_valid = 1, mem_sel = 0.
  - BUSY1 gives gnt1 = 1, mem_valid = 1, mem_sel = 1.
  - IDLE drives all of them to 0; mem_sel holds its last value.
- IDLE transitions:
  - Only req0 high: go to BUSY0.
  - Only req1 high: go to BUSY1.
  - Both high: go to the port that is not last_grant.
  - Neither high: stay in IDLE.
  - Grant latency is 1 cycle from req to gnt.
- BUSYx transitions:
  - Stay in BUSYx while mem_ready = 0.
  - On mem_ready = 1: doneX = 1 combinationally that same cycle (doneX = gntX & mem_ready), and last_grant is set to x.
  - Next state after completion: BUSY of the other port if that port is requesting; otherwise BUSYx if reqX is still high (the requester must drop req the cycle after done, so this path is normally not taken); otherwise IDLE.
  - Back-to-back handover to the other port has zero bubble cycles.
- mem_addr = mem_sel ? addr1 : addr0, combinational through the N-bit 2:1 mux instance.
- Requester drops req while granted: the grant is held until mem_ready; no abort.
- mem_ready while in IDLE is ignored; no done pulse is produced.
- done0 and done1 are never high in the same cycle. gnt0 and gnt1 are mutually exclusive.
- Reset asserted mid-access: state returns to IDLE on that edge, the in-flight access is discarded with no done pulse, and last_grant is set to 1.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro defined:
  - A cycle counter of width $clog2(TIMEOUT) clears on entry to BUSYx and increments each BUSY cycle while mem_ready = 0.
  - When the counter reaches TIMEOUT-1 with mem_ready = 0: pulse timeout_err for 1 cycle, do not pulse done, set last_grant to x, and go to IDLE.
  - If mem_ready arrives in that same cycle, the access completes normally; mem_ready wins.
- Without the macro: no counter, BUSYx waits indefinitely, and timeout_err is constant 0.

Test Plan:
1. Reset, then req0 = 1 with addr0 = 0x100 → gnt0 = 1 and mem_addr = 0x100 the next cycle; mem_ready after 3 cycles → done0 pulses once, then IDLE.
2. req0 and req1 rise together after reset (addr1 = 0x200) → port 0 is granted first; on its mem_ready, the next cycle is BUSY1 with mem_sel = 1 and mem_addr = 0x200, no bubble.
3. Both requests held continuously, each port re-raising req one cycle after its done, mem_ready every 2nd cycle → grants alternate 0,1,0,1 over 8 accesses, with exactly one doneX per completion.
4. rst asserted while in BUSY1 with mem_ready = 0 → the next cycle shows gnt1 = 0, mem_valid = 0, no done1; a subsequent tie grants port 0.
5. ARB_TIMEOUT_EN, TIMEOUT = 4, req1 = 1, mem_ready held 0 → timeout_err pulses exactly 4 cycles after gnt1 rises, no done1, then IDLE.
6. Without the macro, same stimulus as scenario 5 for 100 cycles → gnt1 stays high and timeout_err stays 0 throughout.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (port 0)
// and data access (port 1). Round-robin, grant-hold FSM steering an N-bit
// 2:1 address mux. Optional watchdog abort enabled by defining ARB_TIMEOUT_EN.

// N-bit 2:1 address mux; 0 selects i_a, 1 selects i_b.
module mem_port_arbiter_mux2 #(
   parameter int unsigned N = 32
) (
   input  logic         i_sel,
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   output logic [N-1:0] o_y
);

   assign o_y = i_sel ? i_b : i_a;

endmodule

module mem_port_arbiter #(
   parameter int unsigned N       = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0,
   input  logic         req1,
   input  logic [N-1:0] addr0,
   input  logic [N-1:0] addr1,
   input  logic         mem_ready,
   output logic         gnt0,
   output logic         gnt1,
   output logic         done0,
   output logic         done1,
   output logic         mem_valid,
   output logic         mem_sel,
   output logic [N-1:0] mem_addr,
   output logic         timeout_err
);

   // The watchdog counter cannot express a limit below 2 cycles.
   if (TIMEOUT < 2) begin : g_timeout_check
      $error("mem_port_arbiter: TIMEOUT must be >= 2");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY0 = 2'd1,
      BUSY1 = 2'd2
   } state_t;

   state_t       r_state;
   state_t       w_next_state;
   logic         r_last_grant;
   logic         w_last_grant_nxt;
   logic         w_timeout;

   logic         r_gnt0;
   logic         r_gnt1;
   logic         r_mem_valid;
   logic         r_mem_sel;
   logic         r_timeout_err;
   logic         w_gnt0_nxt;
   logic         w_gnt1_nxt;
   logic         w_mem_valid_nxt;
   logic         w_mem_sel_nxt;
   logic         w_timeout_err_nxt;
   logic [N-1:0] w_mem_addr;

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [CNT_W-1:0] r_cnt;

   // Abort only when the limit is reached without mem_ready; a late ready still completes.
   assign w_timeout = (r_state != IDLE) && !mem_ready &&
                      (r_cnt == CNT_W'(TIMEOUT - 1));

   // Busy-cycle counter: restarts with every new access, counts stalled cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if ((r_state == IDLE) || mem_ready || (w_next_state != r_state)) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end
`else
   assign w_timeout = 1'b0;
`endif

   // State register plus round-robin history and registered output decodes.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_last_grant  <= 1'b1;
         r_gnt0        <= 1'b0;
         r_gnt1        <= 1'b0;
         r_mem_valid   <= 1'b0;
         r_mem_sel     <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         r_state       <= w_next_state;
         r_last_grant  <= w_last_grant_nxt;
         r_gnt0        <= w_gnt0_nxt;
         r_gnt1        <= w_gnt1_nxt;
         r_mem_valid   <= w_mem_valid_nxt;
         r_mem_sel     <= w_mem_sel_nxt;
         r_timeout_err <= w_timeout_err_nxt;
      end
   end

   // Next-state: round-robin on ties, hold grant until mem_ready, prefer handover.
   always_comb begin
      w_next_state     = r_state;
      w_last_grant_nxt = r_last_grant;
      case (r_state)
         IDLE: begin
            if (req0 && req1) begin
               w_next_state = r_last_grant ? BUSY0 : BUSY1;
            end else if (req0) begin
               w_next_state = BUSY0;
            end else if (req1) begin
               w_next_state = BUSY1;
            end
         end
         BUSY0: begin
            if (mem_ready) begin
               w_last_grant_nxt = 1'b0;
               if (req1) begin
                  w_next_state = BUSY1;
               end else if (req0) begin
                  w_next_state = BUSY0;
               end else begin
                  w_next_state = IDLE;
               end
            end else if (w_timeout) begin
               w_last_grant_nxt = 1'b0;
               w_next_state     = IDLE;
            end
         end
         BUSY1: begin
            if (mem_ready) begin
               w_last_grant_nxt = 1'b1;
               if (req0) begin
                  w_next_state = BUSY0;
               end else if (req1) begin
                  w_next_state = BUSY1;
               end else begin
                  w_next_state = IDLE;
               end
            end else if (w_timeout) begin
               w_last_grant_nxt = 1'b1;
               w_next_state     = IDLE;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   // Output decode of the next state so the registered outputs track the state.
   always_comb begin
      w_gnt0_nxt        = 1'b0;
      w_gnt1_nxt        = 1'b0;
      w_mem_valid_nxt   = 1'b0;
      w_mem_sel_nxt     = r_mem_sel;
      w_timeout_err_nxt = w_timeout;
      case (w_next_state)
         BUSY0: begin
            w_gnt0_nxt      = 1'b1;
            w_mem_valid_nxt = 1'b1;
            w_mem_sel_nxt   = 1'b0;
         end
         BUSY1: begin
            w_gnt1_nxt      = 1'b1;
            w_mem_valid_nxt = 1'b1;
            w_mem_sel_nxt   = 1'b1;
         end
         default: begin
            w_mem_sel_nxt = r_mem_sel;
         end
      endcase
   end

   // Address steering through the shared mux instance.
   mem_port_arbiter_mux2 #(
      .N (N)
   ) u_addr_mux (
      .i_sel (r_mem_sel),
      .i_a   (addr0),
      .i_b   (addr1),
      .o_y   (w_mem_addr)
   );

   assign gnt0        = r_gnt0;
   assign gnt1        = r_gnt1;
   assign mem_valid   = r_mem_valid;
   assign mem_sel     = r_mem_sel;
   assign mem_addr    = w_mem_addr;
   assign timeout_err = r_timeout_err;

   // Completion pulses; an access interrupted by reset is discarded silently.
   assign done0 = r_gnt0 && mem_ready && !rst;
   assign done1 = r_gnt1 && mem_ready && !rst;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level arbitration model.
module tb_mem_port_arbiter;

   localparam int unsigned N  = 32;
   localparam int unsigned TO = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         req0;
   logic         req1;
   logic [N-1:0] addr0;
   logic [N-1:0] addr1;
   logic         mem_ready;
   logic         gnt0;
   logic         gnt1;
   logic         done0;
   logic         done1;
   logic         mem_valid;
   logic         mem_sel;
   logic [N-1:0] mem_addr;
   logic         timeout_err;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: current owner (-1 none), last winner, mux select, abort flag.
   int   m_owner;
   int   m_last;
   int   m_stall;
   logic m_sel;
   logic m_terr;

   mem_port_arbiter #(
      .N       (N),
      .TIMEOUT (TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req0        (req0),
      .req1        (req1),
      .addr0       (addr0),
      .addr1       (addr1),
      .mem_ready   (mem_ready),
      .gnt0        (gnt0),
      .gnt1        (gnt1),
      .done0       (done0),
      .done1       (done1),
      .mem_valid   (mem_valid),
      .mem_sel     (mem_sel),
      .mem_addr    (mem_addr),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req0      = 1'b0;
      req1      = 1'b0;
      mem_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      req0      = 1'b1;
      req1      = 1'b1;
      mem_ready = 1'b1;
      addr0     = '0;
      addr1     = '0;
      tick();
      tick();
      @(negedge clk);
      n_checks++;
      if ({gnt0, gnt1, done0, done1, mem_valid, mem_sel, timeout_err} !== 7'b0) begin
         $display("FAIL reset_outputs: got %b expected 0000000",
                  {gnt0, gnt1, done0, done1, mem_valid, mem_sel, timeout_err});
      end else n_pass++;
      tick();
      req0      = 1'b0;
      req1      = 1'b0;
      mem_ready = 1'b0;
      rst       = 1'b0;
      tick();
   endtask

   task automatic test_single();
      do_reset();
      addr0 = 32'h0000_0100;
      addr1 = 32'hDEAD_0000;
      req0  = 1'b1;
      @(negedge clk);
      n_checks++;
      if (gnt0 !== 1'b0) $display("FAIL single_latency: gnt0 got %b expected 0", gnt0);
      else n_pass++;
      tick();
      @(negedge clk);
      n_checks++;
      if ({gnt0, gnt1, mem_valid, mem_sel} !== 4'b1010)
         $display("FAIL single_grant: got %b expected 1010", {gnt0, gnt1, mem_valid, mem_sel});
      else n_pass++;
      n_checks++;
      if (mem_addr !== 32'h0000_0100)
         $display("FAIL single_addr: got %h expected 00000100", mem_addr);
      else n_pass++;
      tick();
      tick();
      @(negedge clk);
      n_checks++;
      if ({gnt0, done0} !== 2'b10) $display("FAIL single_hold: got %b expected 10", {gnt0, done0});
      else n_pass++;
      tick();
      mem_ready = 1'b1;
      req0      = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({done0, done1} !== 2'b10) $display("FAIL single_done: got %b expected 10", {done0, done1});
      else n_pass++;
      tick();
      mem_ready = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({gnt0, mem_valid, done0, mem_sel} !== 4'b0000)
         $display("FAIL single_idle: got %b expected 0000", {gnt0, mem_valid, done0, mem_sel});
      else n_pass++;
      tick();
   endtask

   task automatic test_tie();
      do_reset();
      addr0 = 32'h0000_0100;
      addr1 = 32'h0000_0200;
      req0  = 1'b1;
      req1  = 1'b1;
      tick();
      mem_ready = 1'b1;
      req0      = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({gnt0, gnt1, done0, done1} !== 4'b1010)
         $display("FAIL tie_first: got %b expected 1010", {gnt0, gnt1, done0, done1});
      else n_pass++;
      tick();
      mem_ready = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({gnt0, gnt1, mem_valid, mem_sel, done0} !== 5'b01110)
         $display("FAIL tie_handover: got %b expected 01110", {gnt0, gnt1, mem_valid, mem_sel, done0});
      else n_pass++;
      n_checks++;
      if (mem_addr !== 32'h0000_0200) $display("FAIL tie_addr: got %h expected 00000200", mem_addr);
      else n_pass++;
      tick();
      mem_ready = 1'b1;
      req1      = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({done0, done1} !== 2'b01) $display("FAIL tie_done1: got %b expected 01", {done0, done1});
      else n_pass++;
      tick();
      mem_ready = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({mem_valid, mem_sel} !== 2'b01)
         $display("FAIL tie_sel_hold: got %b expected 01", {mem_valid, mem_sel});
      else n_pass++;
      tick();
   endtask

   task automatic test_alternate();
      int n_done;
      n_done = 0;
      do_reset();
      req0 = 1'b1;
      req1 = 1'b1;
      tick();
      for (int k = 0; k < 8; k++) begin
         mem_ready = 1'b0;
         if (k > 0) begin
            if (k % 2 == 0) req1 = 1'b1;
            else            req0 = 1'b1;
         end
         @(negedge clk);
         n_checks++;
         if ({gnt0, gnt1, done0, done1} !== ((k % 2 == 0) ? 4'b1000 : 4'b0100))
            $display("FAIL alt_grant_%0d: got %b expected %b", k, {gnt0, gnt1, done0, done1},
                     (k % 2 == 0) ? 4'b1000 : 4'b0100);
         else n_pass++;
         tick();
         mem_ready = 1'b1;
         if (k % 2 == 0) req0 = 1'b0;
         else            req1 = 1'b0;
         @(negedge clk);
         n_done += int'(done0) + int'(done1);
         n_checks++;
         if ({done0, done1} !== ((k % 2 == 0) ? 2'b10 : 2'b01))
            $display("FAIL alt_done_%0d: got %b expected %b", k, {done0, done1},
                     (k % 2 == 0) ? 2'b10 : 2'b01);
         else n_pass++;
         tick();
      end
      n_checks++;
      if (n_done !== 8) $display("FAIL alt_done_count: got %0d expected 8", n_done);
      else n_pass++;
      do_reset();
   endtask

   task automatic test_reset_mid();
      do_reset();
      addr0 = 32'h0000_0010;
      addr1 = 32'h0000_0300;
      req0  = 1'b1;
      tick();
      mem_ready = 1'b1;
      req0      = 1'b0;
      req1      = 1'b1;
      tick();
      mem_ready = 1'b0;
      @(negedge clk);
      n_checks++;
      if (gnt1 !== 1'b1) $display("FAIL rstmid_busy1: gnt1 got %b expected 1", gnt1);
      else n_pass++;
      tick();
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if (done1 !== 1'b0) $display("FAIL rstmid_no_done: done1 got %b expected 0", done1);
      else n_pass++;
      tick();
      rst  = 1'b0;
      req0 = 1'b1;
      req1 = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({gnt1, mem_valid, done1, mem_sel} !== 4'b0000)
         $display("FAIL rstmid_cleared: got %b expected 0000", {gnt1, mem_valid, done1, mem_sel});
      else n_pass++;
      tick();
      @(negedge clk);
      n_checks++;
      if ({gnt0, gnt1} !== 2'b10) $display("FAIL rstmid_tie: got %b expected 10", {gnt0, gnt1});
      else n_pass++;
      do_reset();
   endtask

   task automatic test_idle_ready();
      do_reset();
      mem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if ({done0, done1, mem_valid} !== 3'b000)
            $display("FAIL idle_ready_%0d: got %b expected 000", i, {done0, done1, mem_valid});
         else n_pass++;
         tick();
      end
      mem_ready = 1'b0;
   endtask

   task automatic test_timeout();
      do_reset();
      req1 = 1'b1;
      tick();
      @(negedge clk);
      n_checks++;
      if ({gnt1, timeout_err} !== 2'b10)
         $display("FAIL to_grant: got %b expected 10", {gnt1, timeout_err});
      else n_pass++;
`ifdef ARB_TIMEOUT_EN
      for (int i = 1; i < 4; i++) begin
         tick();
         @(negedge clk);
         n_checks++;
         if ({gnt1, timeout_err} !== 2'b10)
            $display("FAIL to_wait_%0d: got %b expected 10", i, {gnt1, timeout_err});
         else n_pass++;
      end
      tick();
      req1 = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({timeout_err, gnt1, done1, mem_valid} !== 4'b1000)
         $display("FAIL to_abort: got %b expected 1000", {timeout_err, gnt1, done1, mem_valid});
      else n_pass++;
      tick();
      @(negedge clk);
      n_checks++;
      if ({timeout_err, gnt1} !== 2'b00)
         $display("FAIL to_pulse_end: got %b expected 00", {timeout_err, gnt1});
      else n_pass++;
`else
      for (int i = 1; i <= 100; i++) begin
         tick();
         @(negedge clk);
         n_checks++;
         if ({gnt1, timeout_err, done1} !== 3'b100)
            $display("FAIL to_hold_%0d: got %b expected 100", i, {gnt1, timeout_err, done1});
         else n_pass++;
      end
`endif
      do_reset();
   endtask

   task automatic test_random();
      logic [6:0]   exp_v;
      logic [N-1:0] exp_a;
      logic [1:0]   rq;
      int           x;
      do_reset();
      m_owner = -1;
      m_last  = 1;
      m_stall = 0;
      m_sel   = 1'b0;
      m_terr  = 1'b0;
      for (int i = 0; i < 600; i++) begin
         rst       = ($urandom_range(0, 39) == 0);
         req0      = ($urandom_range(0, 3) != 0);
         req1      = ($urandom_range(0, 3) != 0);
         mem_ready = ($urandom_range(0, 2) == 0);
         addr0     = $urandom;
         addr1     = $urandom;
         @(negedge clk);
         exp_v = {m_owner == 0, m_owner == 1,
                  (m_owner == 0) && mem_ready && !rst,
                  (m_owner == 1) && mem_ready && !rst,
                  m_owner >= 0, m_sel, m_terr};
         exp_a = m_sel ? addr1 : addr0;
         n_checks++;
         if ({gnt0, gnt1, done0, done1, mem_valid, mem_sel, timeout_err} !== exp_v)
            $display("FAIL rand_ctrl_%0d: got %b expected %b", i,
                     {gnt0, gnt1, done0, done1, mem_valid, mem_sel, timeout_err}, exp_v);
         else n_pass++;
         n_checks++;
         if (mem_addr !== exp_a) $display("FAIL rand_addr_%0d: got %h expected %h", i, mem_addr, exp_a);
         else n_pass++;
         @(posedge clk);
         rq = {req1, req0};
         if (rst) begin
            m_owner = -1;
            m_last  = 1;
            m_stall = 0;
            m_sel   = 1'b0;
            m_terr  = 1'b0;
         end else begin
            m_terr = 1'b0;
            if (m_owner < 0) begin
               if (rq == 2'b11)   m_owner = 1 - m_last;
               else if (rq[0])    m_owner = 0;
               else if (rq[1])    m_owner = 1;
               m_stall = 0;
            end else if (mem_ready) begin
               x       = m_owner;
               m_last  = x;
               m_stall = 0;
               if (rq[1 - x])     m_owner = 1 - x;
               else if (rq[x])    m_owner = x;
               else               m_owner = -1;
            end else begin
               m_stall++;
`ifdef ARB_TIMEOUT_EN
               if (m_stall >= int'(TO)) begin
                  m_terr  = 1'b1;
                  m_last  = m_owner;
                  m_owner = -1;
                  m_stall = 0;
               end
`endif
            end
            if (m_owner >= 0) m_sel = (m_owner == 1);
         end
         #1;
      end
      do_reset();
   endtask

   initial begin
      test_reset();
      test_single();
      test_tie();
      test_alternate();
      test_reset_mid();
      test_idle_ready();
      test_timeout();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
